// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS next-PC logic: sequencer state encodings
// and default vector addresses.
package mips_pkg;

   typedef enum logic [1:0] {
      SEQ_BOOT = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_HALT = 2'd2
   } seq_state_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
   localparam int          PC_INC           = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational candidate-target generator: sequential, branch and jump
// addresses derived from the current PC.
module pc_target_calc
   import mips_pkg::*;
#(
   parameter int N_BIT = 32
) (
   input  logic [N_BIT-1:0] pc,
   input  logic [N_BIT-1:0] branch_offset,
   input  logic [25:0]      jump_index,
   output logic [N_BIT-1:0] pc_plus4,
   output logic [N_BIT-1:0] branch_target,
   output logic [N_BIT-1:0] jump_target
);

   // All sums wrap silently modulo 2^N_BIT.
   assign pc_plus4      = pc + N_BIT'(PC_INC);
   assign branch_target = pc_plus4 + {branch_offset[N_BIT-3:0], 2'b00};
   assign jump_target   = {pc_plus4[N_BIT-1:N_BIT-4], jump_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot/run/halt sequencing, exception entry/return
// tracking and the prioritised redirect mux feeding the PC register.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter int               N_BIT        = 32,
   parameter logic [N_BIT-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [N_BIT-1:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_BIT-1:0] pc,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [N_BIT-1:0] branch_offset,
   input  logic             jump,
   input  logic [25:0]      jump_index,
   input  logic             jr,
   input  logic [N_BIT-1:0] jr_target,
   input  logic             exception,
   input  logic             eret,
   input  logic             halt_req,
   input  logic             resume,
   output logic [N_BIT-1:0] pc_dash,
   output logic [N_BIT-1:0] epc,
   output logic             exc_active,
   output logic [1:0]       seq_state
);

   seq_state_t       state_reg, state_next;
   logic [N_BIT-1:0] epc_reg, epc_next;
   logic             exc_active_reg, exc_active_next;
   logic [N_BIT-1:0] pc_plus4, branch_target, jump_target;

   pc_target_calc #(.N_BIT(N_BIT)) u_target_calc (
      .pc            (pc),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target),
      .jump_target   (jump_target)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= SEQ_BOOT;
         epc_reg        <= '0;
         exc_active_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         epc_reg        <= epc_next;
         exc_active_reg <= exc_active_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      epc_next        = epc_reg;
      exc_active_next = exc_active_reg;
      pc_dash         = pc;
      unique case (state_reg)
         SEQ_BOOT: begin
            pc_dash    = RESET_VECTOR;
            state_next = SEQ_RUN;
         end
         SEQ_RUN: begin
            // Masked exceptions and stray erets fall through to lower rules.
            if (exception && !exc_active_reg) begin
               pc_dash         = EXC_VECTOR;
               epc_next        = pc;
               exc_active_next = 1'b1;
            end else if (eret && exc_active_reg) begin
               pc_dash         = epc_reg;
               exc_active_next = 1'b0;
            end else if (halt_req) begin
               pc_dash    = pc;
               state_next = SEQ_HALT;
            end else if (stall) begin
               pc_dash = pc;
            end else if (jr) begin
               pc_dash = jr_target;
            end else if (jump) begin
               pc_dash = jump_target;
            end else if (branch_taken) begin
               pc_dash = branch_target;
            end else begin
               pc_dash = pc_plus4;
            end
         end
         SEQ_HALT: begin
            if (resume) begin
               pc_dash    = pc_plus4;
               state_next = SEQ_RUN;
            end else begin
               pc_dash = pc;
            end
         end
         default: begin
            pc_dash    = RESET_VECTOR;
            state_next = SEQ_BOOT;
         end
      endcase
   end

   assign epc        = epc_reg;
   assign exc_active = exc_active_reg;
   assign seq_state  = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a local PC register; expected PCs are
// queued when stimulus is applied and checked after the capturing edge.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc;
   logic        stall, branch_taken, jump, jr, exception, eret, halt_req, resume;
   logic [31:0] branch_offset, jr_target;
   logic [25:0] jump_index;
   logic [31:0] pc_dash, epc;
   logic        exc_active;
   logic [1:0]  seq_state;

   logic        load_en;
   logic [31:0] load_val;
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // PC register model: reset value equals RESET_VECTOR; load_en lets the bench preset it.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)     pc <= 32'h0;
      else if (load_en) pc <= load_val;
      else              pc <= pc_dash;
   end

   pc_sequencer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc            (pc),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_index    (jump_index),
      .jr            (jr),
      .jr_target     (jr_target),
      .exception     (exception),
      .eret          (eret),
      .halt_req      (halt_req),
      .resume        (resume),
      .pc_dash       (pc_dash),
      .epc           (epc),
      .exc_active    (exc_active),
      .seq_state     (seq_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic clear_inputs();
      stall = 0; branch_taken = 0; jump = 0; jr = 0; exception = 0;
      eret = 0; halt_req = 0; resume = 0;
      branch_offset = 0; jr_target = 0; jump_index = 0;
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic step(input string tag, input logic [31:0] exp_dash);
      logic [31:0] exp_pc;
      #1;
      chk({tag, "_dash"}, pc_dash, exp_dash);
      exp_q.push_back(exp_dash);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         exp_pc = exp_q.pop_front();
         chk({tag, "_pc"}, pc, exp_pc);
      end
      $display("txn %s pc=%h pc_dash_next=%h state=%0d epc=%h exc=%0b",
               tag, pc, pc_dash, seq_state, epc, exc_active);
   endtask

   task automatic load_pc(input logic [31:0] v);
      load_en = 1; load_val = v;
      @(posedge clk);
      @(negedge clk);
      load_en = 0;
   endtask

   initial begin
      reset_n = 0; load_en = 0; load_val = 0;
      clear_inputs();
      #1;
      chk("rst_state", {30'd0, seq_state}, 32'd0);
      chk("rst_epc", epc, 32'd0);
      chk("rst_exc", {31'd0, exc_active}, 32'd0);
      chk("rst_dash", pc_dash, 32'd0);

      // Reset release: pc 0, 0, 4, 8
      @(negedge clk);
      reset_n = 1;
      step("boot", 32'h0);
      chk("boot_to_run", {30'd0, seq_state}, 32'd1);
      step("seq0", 32'h4);
      step("seq1", 32'h8);
      chk("seq_epc", epc, 32'd0);

      // Branch and jump priority
      load_pc(32'h0040_0010);
      branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
      #1 chk("branch_dash", pc_dash, 32'h0040_000C);
      jump = 1; jump_index = 26'h010_0000;
      step("jump_over_branch", 32'h0040_0000);
      clear_inputs();

      // Exception entry, masked nesting, return
      load_pc(32'h0000_0100);
      exception = 1;
      step("exc_entry", 32'h80);
      chk("exc_epc", epc, 32'h100);
      chk("exc_active", {31'd0, exc_active}, 32'd1);
      exception = 0;
      step("handler", 32'h84);
      exception = 1;
      step("exc_masked", 32'h88);
      chk("exc_masked_epc", epc, 32'h100);
      exception = 0; eret = 1;
      step("eret", 32'h100);
      chk("eret_exc", {31'd0, exc_active}, 32'd0);
      step("eret_ignored", 32'h104);
      clear_inputs();

      // Stall beats jr
      load_pc(32'h20);
      stall = 1;
      for (int i = 0; i < 3; i++) step("stall", 32'h20);
      jr = 1; jr_target = 32'h400;
      step("stall_jr", 32'h20);
      stall = 0;
      step("jr", 32'h400);
      clear_inputs();

      // Halt, ignored branch, resume beats halt_req
      load_pc(32'h30);
      halt_req = 1;
      step("halt_req", 32'h30);
      chk("halt_state", {30'd0, seq_state}, 32'd2);
      halt_req = 0; branch_taken = 1; branch_offset = 32'h10;
      for (int i = 0; i < 5; i++) step("halted", 32'h30);
      resume = 1; halt_req = 1;
      step("resume", 32'h34);
      chk("resume_state", {30'd0, seq_state}, 32'd1);
      clear_inputs();

      // Wrap at top of address space
      load_pc(32'hFFFF_FFFC);
      step("wrap", 32'h0);

      // Enter handler, halt, then async reset mid-cycle
      exception = 1;
      step("exc2", 32'h80);
      exception = 0; halt_req = 1;
      step("halt_in_handler", 32'h80);
      halt_req = 0;
      chk("pre_rst_exc", {31'd0, exc_active}, 32'd1);
      chk("pre_rst_state", {30'd0, seq_state}, 32'd2);
      #2 reset_n = 0;
      #1;
      chk("arst_state", {30'd0, seq_state}, 32'd0);
      chk("arst_epc", epc, 32'd0);
      chk("arst_exc", {31'd0, exc_active}, 32'd0);
      chk("arst_dash", pc_dash, 32'd0);
      chk("arst_pc", pc, 32'd0);

      // BOOT ignores inputs
      @(negedge clk);
      reset_n = 1; branch_taken = 1; branch_offset = 32'h4; jr = 1; jr_target = 32'h200;
      step("boot_ignore", 32'h0);
      chk("boot2_run", {30'd0, seq_state}, 32'd1);
      clear_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
